issue_sched: RTL and testbench

- Issue scheduler for the front-end instruction buffer.
- Mirrors buffer occupancy with its own counter and inspects the two head instructions.
- Each cycle it decides whether to issue 0, 1 or 2 instructions, and drives the buffer's issue strobe and issue mode.
- Also throttles fetch near full, and holds a branch at the head until its delay slot is buffered, so branch and delay slot always issue as one dual pair.

---
 rtl/issue_sched_if.sv | 28 ++
 rtl/issue_sched.sv | 151 +++++++++++++++
 tb/tb_issue_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/issue_sched_if.sv
// Scheduler <-> instruction buffer bundle: enqueue strobes, head instructions,
// issue strobe/mode and status flags.
interface issue_sched_if #(
    parameter int CNT_W = 6
);
    logic             flush;
    logic             enq_valid1;
    logic             enq_valid2;
    logic [31:0]      head_inst1;
    logic [31:0]      head_inst2;
    logic             stall_i;
    logic             issue_o;
    logic             issue_mode_o;
    logic [CNT_W-1:0] count_o;
    logic             fetch_stall_o;
    logic             ds_wait_o;
    logic             overflow_o;

    modport master (
        output flush, enq_valid1, enq_valid2, head_inst1, head_inst2, stall_i,
        input  issue_o, issue_mode_o, count_o, fetch_stall_o, ds_wait_o, overflow_o
    );

    modport slave (
        input  flush, enq_valid1, enq_valid2, head_inst1, head_inst2, stall_i,
        output issue_o, issue_mode_o, count_o, fetch_stall_o, ds_wait_o, overflow_o
    );
endinterface

// File: rtl/issue_sched.sv
// Dual-issue scheduler: tracks buffer occupancy, decodes the two head instructions
// and keeps a branch and its delay slot together as one dual issue.
module issue_sched #(
    parameter int BUF_DEPTH   = 32,
    parameter int CNT_W       = 6,
    parameter int FULL_MARGIN = 7
) (
    input  logic         clk,
    input  logic         rst,
    issue_sched_if.slave bus
);
    localparam int CW1 = CNT_W + 1;

    typedef enum logic [1:0] {RUN, DS_WAIT, FLUSH_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fetch_stall_q, fetch_stall_d;
    logic             overflow_q, overflow_d;
    logic             issue, issue_mode, ds_wait;

    logic [CW1-1:0]   enq_w, deq_w, sum_w;
    logic             br1, br2, mem1, mem2, raw;
    logic [5:0]       dest1;
    logic             cnt_ge1, cnt_ge2;
    logic             unused_bits;

    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
        return (op == 6'b000001) || (op == 6'b000010) || (op == 6'b000011) ||
               (op[5:2] == 4'b0001) ||
               ((op == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001)));
    endfunction

    // Returns {valid, reg}; writes to $0 are treated as having no destination.
    function automatic logic [5:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == 6'b000000)                             d = rd;
        else if (op[5:3] == 3'b001 || op[5:3] == 3'b100) d = rt;
        else if (op == 6'b000011)                        d = 5'd31;
        return {(d != 5'd0), d};
    endfunction

    function automatic logic reads_reg(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] r);
        logic rs_v, rt_v;
        rs_v = !((op == 6'b000010) || (op == 6'b000011));
        rt_v = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
               (op[5:3] == 3'b101);
        return (rs_v && (rs == r)) || (rt_v && (rt == r));
    endfunction

    assign unused_bits = ^{bus.head_inst1[25:21], bus.head_inst1[10:6], bus.head_inst2[15:6]};

    always_comb begin
        br1   = is_branch(bus.head_inst1[31:26], bus.head_inst1[5:0]);
        br2   = is_branch(bus.head_inst2[31:26], bus.head_inst2[5:0]);
        mem1  = bus.head_inst1[31];
        mem2  = bus.head_inst2[31];
        dest1 = dest_of(bus.head_inst1[31:26], bus.head_inst1[20:16], bus.head_inst1[15:11]);
        raw   = dest1[5] && reads_reg(bus.head_inst2[31:26], bus.head_inst2[25:21],
                                      bus.head_inst2[20:16], dest1[4:0]);
        cnt_ge1 = (count_q >= CNT_W'(1));
        cnt_ge2 = (count_q >= CNT_W'(2));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH_HOLD;
        end else if (!bus.stall_i) begin
            case (state_q)
                RUN:        if (br1 && (count_q == CNT_W'(1))) state_d = DS_WAIT;
                DS_WAIT:    if (cnt_ge2) state_d = RUN;
                FLUSH_HOLD: state_d = RUN;
                default:    state_d = RUN;
            endcase
        end
    end

    // A head branch always goes out together with its delay slot, ignoring hazards.
    always_comb begin
        issue      = 1'b0;
        issue_mode = 1'b0;
        ds_wait    = (state_q == DS_WAIT);
        if (!bus.stall_i) begin
            case (state_q)
                RUN: begin
                    if (br1) begin
                        if (cnt_ge2) begin
                            issue      = 1'b1;
                            issue_mode = 1'b1;
                        end
                    end else if (cnt_ge2 && !raw && !br2 && !(mem1 && mem2)) begin
                        issue      = 1'b1;
                        issue_mode = 1'b1;
                    end else if (cnt_ge1) begin
                        issue = 1'b1;
                    end
                end
                DS_WAIT: begin
                    if (cnt_ge2) begin
                        issue      = 1'b1;
                        issue_mode = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        enq_w = CW1'(bus.enq_valid1) + CW1'(bus.enq_valid1 & bus.enq_valid2);
        deq_w = issue ? (issue_mode ? CW1'(2) : CW1'(1)) : CW1'(0);
        sum_w = {1'b0, count_q} + enq_w - deq_w;
        count_d    = sum_w[CNT_W-1:0];
        overflow_d = overflow_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (sum_w > CW1'(BUF_DEPTH)) begin
            count_d    = CNT_W'(BUF_DEPTH);
            overflow_d = 1'b1;
        end
        fetch_stall_d = ({1'b0, count_d} >= CW1'(BUF_DEPTH - FULL_MARGIN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            fetch_stall_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            fetch_stall_q <= fetch_stall_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.issue_o       = issue;
    assign bus.issue_mode_o  = issue_mode;
    assign bus.ds_wait_o     = ds_wait;
    assign bus.count_o       = count_q;
    assign bus.fetch_stall_o = fetch_stall_q;
    assign bus.overflow_o    = overflow_q;
endmodule

// File: tb/tb_issue_sched.sv
// Directed vector bench for issue_sched: a table of per-cycle inputs and hand-computed
// outputs, followed by an asynchronous reset taken in the middle of DS_WAIT.
module tb_issue_sched;
    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    issue_sched_if #(.CNT_W(6)) bus ();

    issue_sched #(.BUF_DEPTH(32), .CNT_W(6), .FULL_MARGIN(7)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        e1;
        logic        e2;
        logic [31:0] h1;
        logic [31:0] h2;
        logic        stall;
        logic        x_issue;
        logic        x_mode;
        int          x_count;
        logic        x_fs;
        logic        x_dw;
        logic        x_ov;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    function automatic void addVec(input logic fl, input logic e1, input logic e2,
                                   input logic [31:0] h1, input logic [31:0] h2,
                                   input logic st, input logic xi, input logic xm,
                                   input int xc, input logic xf, input logic xd,
                                   input logic xo);
        vec_t v;
        v.flush = fl; v.e1 = e1; v.e2 = e2; v.h1 = h1; v.h2 = h2; v.stall = st;
        v.x_issue = xi; v.x_mode = xm; v.x_count = xc;
        v.x_fs = xf; v.x_dw = xd; v.x_ov = xo;
        vecs.push_back(v);
    endfunction

    task automatic checkField(input string name, input int idx, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s (vec %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.flush      = v.flush;
        bus.enq_valid1 = v.e1;
        bus.enq_valid2 = v.e2;
        bus.head_inst1 = v.h1;
        bus.head_inst2 = v.h2;
        bus.stall_i    = v.stall;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("issue_o", idx, int'(bus.issue_o), int'(v.x_issue));
        if (v.x_issue) checkField("issue_mode_o", idx, int'(bus.issue_mode_o), int'(v.x_mode));
        checkField("count_o", idx, int'(bus.count_o), v.x_count);
        checkField("fetch_stall_o", idx, int'(bus.fetch_stall_o), int'(v.x_fs));
        checkField("ds_wait_o", idx, int'(bus.ds_wait_o), int'(v.x_dw));
        checkField("overflow_o", idx, int'(bus.overflow_o), int'(v.x_ov));
    endtask

    initial begin
        logic [31:0] ia, ib, is, ibq, ilw, isw, iz0, iz1;
        vec_t hv;

        n_compared   = 0;
        n_mismatched = 0;
        ia  = rtype(5'd1, 5'd2, 5'd3, 6'b100001);
        ib  = rtype(5'd4, 5'd5, 5'd6, 6'b100001);
        is  = rtype(5'd3, 5'd5, 5'd4, 6'b100011);
        ibq = itype(6'b000100, 5'd1, 5'd2);
        ilw = itype(6'b100011, 5'd1, 5'd7);
        isw = itype(6'b101011, 5'd9, 5'd8);
        iz0 = rtype(5'd1, 5'd2, 5'd0, 6'b100001);
        iz1 = rtype(5'd0, 5'd0, 5'd5, 6'b100001);

        //      fl e1 e2 h1   h2   st | iss mode cnt fs dw ov
        addVec(0, 1, 1, ia,  ib,  0,   0, 0, 0,  0, 0, 0);
        addVec(0, 1, 1, ia,  ib,  0,   1, 1, 2,  0, 0, 0);
        addVec(0, 1, 1, ia,  ib,  0,   1, 1, 2,  0, 0, 0);
        addVec(0, 0, 0, ia,  ib,  0,   1, 1, 2,  0, 0, 0);
        addVec(0, 0, 0, ia,  ib,  0,   0, 0, 0,  0, 0, 0);
        addVec(0, 1, 1, ia,  is,  0,   0, 0, 0,  0, 0, 0);
        addVec(0, 0, 0, ia,  is,  0,   1, 0, 2,  0, 0, 0);
        addVec(0, 0, 0, ibq, ia,  0,   0, 0, 1,  0, 0, 0);
        addVec(0, 1, 0, ibq, ia,  0,   0, 0, 1,  0, 1, 0);
        addVec(0, 0, 0, ibq, ib,  0,   1, 1, 2,  0, 1, 0);
        addVec(0, 0, 0, ia,  ib,  0,   0, 0, 0,  0, 0, 0);
        addVec(0, 1, 1, ilw, isw, 0,   0, 0, 0,  0, 0, 0);
        addVec(0, 0, 0, ilw, isw, 0,   1, 0, 2,  0, 0, 0);
        addVec(0, 1, 1, ib,  ibq, 0,   1, 0, 1,  0, 0, 0);
        addVec(0, 0, 0, ib,  ibq, 0,   1, 0, 2,  0, 0, 0);
        addVec(0, 0, 0, ib,  ia,  0,   1, 0, 1,  0, 0, 0);
        addVec(0, 1, 1, iz0, iz1, 0,   0, 0, 0,  0, 0, 0);
        addVec(0, 0, 0, iz0, iz1, 0,   1, 1, 2,  0, 0, 0);
        addVec(0, 1, 1, ibq, is,  0,   0, 0, 0,  0, 0, 0);
        addVec(0, 0, 0, ibq, is,  0,   1, 1, 2,  0, 0, 0);
        for (int k = 0; k < 13; k++)
            addVec(0, 1, 1, ia, ib, 1, 0, 0, 2 * k, (2 * k >= 25), 0, 0);
        for (int j = 0; j < 4; j++)
            addVec(0, 1, 1, ia, ib, 1, 0, 0, 26 + 2 * j, 1, 0, 0);
        addVec(1, 0, 0, ia,  ib,  1,   0, 0, 32, 1, 0, 1);
        for (int k = 0; k < 5; k++)
            addVec(0, 1, 1, ia, ib, 1, 0, 0, 2 * k, 0, 0, 1);
        addVec(0, 0, 0, ia,  ib,  0,   0, 0, 10, 0, 0, 1);
        addVec(1, 1, 0, ia,  ib,  1,   0, 0, 10, 0, 0, 1);
        addVec(0, 1, 1, ia,  ib,  0,   0, 0, 0,  0, 0, 1);
        addVec(0, 0, 0, ia,  ib,  0,   1, 1, 2,  0, 0, 1);

        bus.flush = 0; bus.enq_valid1 = 0; bus.enq_valid2 = 0;
        bus.head_inst1 = ia; bus.head_inst2 = ib; bus.stall_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        hv = '{flush: 0, e1: 0, e2: 0, h1: ia, h2: ib, stall: 0,
               x_issue: 0, x_mode: 0, x_count: 0, x_fs: 0, x_dw: 0, x_ov: 0};
        checkOutput(hv, -1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Enter DS_WAIT with overflow still sticky, then pull reset between edges.
        hv = '{flush: 0, e1: 1, e2: 0, h1: ia, h2: ib, stall: 0,
               x_issue: 0, x_mode: 0, x_count: 0, x_fs: 0, x_dw: 0, x_ov: 1};
        applyStimulus(hv);
        checkOutput(hv, 100);
        hv = '{flush: 0, e1: 0, e2: 0, h1: ibq, h2: ia, stall: 0,
               x_issue: 0, x_mode: 0, x_count: 1, x_fs: 0, x_dw: 0, x_ov: 1};
        applyStimulus(hv);
        checkOutput(hv, 101);
        hv.x_dw = 1;
        applyStimulus(hv);
        checkOutput(hv, 102);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        hv = '{flush: 0, e1: 0, e2: 0, h1: ibq, h2: ia, stall: 0,
               x_issue: 0, x_mode: 0, x_count: 0, x_fs: 0, x_dw: 0, x_ov: 0};
        checkOutput(hv, 103);
        @(negedge clk);
        rst_n = 1'b1;
        hv = '{flush: 0, e1: 1, e2: 1, h1: ia, h2: ib, stall: 0,
               x_issue: 0, x_mode: 0, x_count: 0, x_fs: 0, x_dw: 0, x_ov: 0};
        applyStimulus(hv);
        checkOutput(hv, 104);
        hv.e1 = 0; hv.e2 = 0; hv.x_issue = 1; hv.x_mode = 1; hv.x_count = 2;
        applyStimulus(hv);
        checkOutput(hv, 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
